// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data memory with a valid/ready request, fixed LATENCY wait and held response.
// Define DMEM_STATS_EN to add saturating rd_count/wr_count/err_count outputs.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        is_memRead,
   input  logic        is_memWrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byte_en,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] mem_data,
   output logic        rsp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count,
   output logic [15:0] err_count
`endif
);

   localparam int unsigned AW         = $clog2(DEPTH_WORDS);
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  CNT_INIT   = 4'((LATENCY == 0) ? 0 : LATENCY - 1);
   localparam logic        BYPASS     = (LATENCY == 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        cap_rd, cap_wr;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic [31:0] mem [DEPTH_WORDS];

   logic          accept, access;
   logic          acc_rd, acc_wr, acc_err;
   logic [31:0]   acc_addr, acc_wdata;
   logic [3:0]    acc_be;
   logic [AW-1:0] acc_idx;

   assign req_ready = (state == IDLE) && rst_n;
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;

   // With zero latency the access happens at the accept edge, straight from the request inputs.
   assign acc_rd    = BYPASS ? is_memRead  : cap_rd;
   assign acc_wr    = BYPASS ? is_memWrite : cap_wr;
   assign acc_addr  = BYPASS ? addr        : cap_addr;
   assign acc_wdata = BYPASS ? wdata       : cap_wdata;
   assign acc_be    = BYPASS ? byte_en     : cap_be;
   assign acc_idx   = acc_addr[AW+1:2];
   assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT) || (acc_rd && acc_wr);

   always_comb begin
      state_nxt = state;
      access    = 1'b0;
      case (state)
         IDLE: if (accept) begin
            state_nxt = BYPASS ? RESP : WAIT;
            access    = BYPASS;
         end
         WAIT: if (cnt == 4'd0) begin
            state_nxt = RESP;
            access    = 1'b1;
         end
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         cap_rd    <= 1'b0;
         cap_wr    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_be    <= '0;
      end else if (accept) begin
         cnt       <= CNT_INIT;
         cap_rd    <= is_memRead;
         cap_wr    <= is_memWrite;
         cap_addr  <= addr;
         cap_wdata <= wdata;
         cap_be    <= byte_en;
      end else if (state == WAIT && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_data <= '0;
         rsp_err  <= 1'b0;
      end else if (access) begin
         mem_data <= (acc_rd && !acc_err) ? mem[acc_idx] : '0;
         rsp_err  <= acc_err;
      end
   end

   always_ff @(posedge clk) begin
      if (access && acc_wr && !acc_err) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

`ifdef DMEM_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count  <= '0;
         wr_count  <= '0;
         err_count <= '0;
      end else if (access) begin
         if (acc_err) begin
            if (err_count != '1) err_count <= err_count + 16'd1;
         end else if (acc_rd) begin
            if (rd_count != '1) rd_count <= rd_count + 16'd1;
         end else if (acc_wr) begin
            if (wr_count != '1) wr_count <= wr_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=2 and one LATENCY=0 instance, selected by sel.
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, req_valid, is_memRead, is_memWrite, rsp_ready, sel;
   logic [31:0] addr, wdata;
   logic [3:0]  byte_en;

   logic        rr_a, rv_a, re_a, rr_b, rv_b, re_b;
   logic [31:0] md_a, md_b;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] mem_data;
`ifdef DMEM_STATS_EN
   logic [15:0] rdc_a, wrc_a, erc_a, rdc_b, wrc_b, erc_b;
`endif

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(rr_a),
      .is_memRead(is_memRead), .is_memWrite(is_memWrite), .addr(addr), .wdata(wdata),
      .byte_en(byte_en), .rsp_valid(rv_a), .rsp_ready(rsp_ready), .mem_data(md_a), .rsp_err(re_a)
`ifdef DMEM_STATS_EN
      , .rd_count(rdc_a), .wr_count(wrc_a), .err_count(erc_a)
`endif
   );

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_lat0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(rr_b),
      .is_memRead(is_memRead), .is_memWrite(is_memWrite), .addr(addr), .wdata(wdata),
      .byte_en(byte_en), .rsp_valid(rv_b), .rsp_ready(rsp_ready), .mem_data(md_b), .rsp_err(re_b)
`ifdef DMEM_STATS_EN
      , .rd_count(rdc_b), .wr_count(wrc_b), .err_count(erc_b)
`endif
   );

   assign req_ready = sel ? rr_b : rr_a;
   assign rsp_valid = sel ? rv_b : rv_a;
   assign mem_data  = sel ? md_b : md_a;
   assign rsp_err   = sel ? re_b : re_a;

   int total = 0;
   int bad   = 0;
   int exp_rd = 0, exp_wr = 0, exp_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One full transaction; request fields are scrambled after acceptance.
   task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] data, output logic err, output int lat);
      int n;
      is_memRead = rd; is_memWrite = wr; addr = a; wdata = d; byte_en = be; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0; is_memRead = ~rd; is_memWrite = ~wr; addr = ~a; wdata = ~d; byte_en = ~be;
      lat = 1;
      while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
      data = mem_data;
      err  = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      if (!sel) begin
         if (a[1:0] != 2'b00 || a >= 32'h400 || (rd && wr)) exp_err++;
         else if (rd) exp_rd++;
         else if (wr) exp_wr++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      logic        e;
      int          lat, n, acc;

      rst_n = 1'b0; req_valid = 1'b0; is_memRead = 1'b0; is_memWrite = 1'b0;
      addr = '0; wdata = '0; byte_en = '0; rsp_ready = 1'b0; sel = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_mem_data", mem_data, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_req_ready", 32'(req_ready), 32'd1);

      xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e, lat);
      check("st_data", d, 32'd0);
      check("st_err", 32'(e), 32'd0);
      check("st_lat", 32'(lat), 32'd3);
      xact(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
      check("ld_data", d, 32'hDEADBEEF);
      check("ld_err", 32'(e), 32'd0);
      check("ld_lat", 32'(lat), 32'd3);

      xact(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, d, e, lat);
      xact(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
      check("be0_data", d, 32'hDEADBEAA);

      xact(1'b1, 1'b0, 32'h13, 32'h0, 4'h0, d, e, lat);
      check("mis_data", d, 32'd0);
      check("mis_err", 32'(e), 32'd1);
      xact(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, d, e, lat);
      check("oor_data", d, 32'd0);
      check("oor_err", 32'(e), 32'd1);

      xact(1'b0, 1'b1, 32'h0, 32'h12345678, 4'hF, d, e, lat);
      xact(1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, d, e, lat);
      check("oor_st_err", 32'(e), 32'd1);
      xact(1'b0, 1'b1, 32'h12, 32'h00000000, 4'hF, d, e, lat);
      check("mis_st_err", 32'(e), 32'd1);
      xact(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, d, e, lat);
      check("oor_st_nowrite", d, 32'h12345678);
      xact(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
      check("mis_st_nowrite", d, 32'hDEADBEAA);

      xact(1'b1, 1'b1, 32'h10, 32'h0, 4'hF, d, e, lat);
      check("rdwr_err", 32'(e), 32'd1);
      check("rdwr_data", d, 32'd0);

      xact(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, d, e, lat);
      check("be_none_err", 32'(e), 32'd0);
      xact(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
      check("be_none_keep", d, 32'hDEADBEAA);
      xact(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
      check("noop_data", d, 32'd0);
      check("noop_err", 32'(e), 32'd0);

      xact(1'b0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, d, e, lat);
      check("top_st_err", 32'(e), 32'd0);
      xact(1'b1, 1'b0, 32'h3FC, 32'h0, 4'h0, d, e, lat);
      check("top_ld_data", d, 32'hA5A5A5A5);

      xact(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b1010, d, e, lat);
      xact(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
      check("be_1010_data", d, 32'h11AD33AA);

      // Response back-pressure
      is_memRead = 1'b1; is_memWrite = 1'b0; addr = 32'h10; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
      for (int i = 0; i < 5; i++) begin
         check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         check("hold_mem_data", mem_data, 32'h11AD33AA);
         check("hold_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_rd++;
      check("rel_req_ready", 32'(req_ready), 32'd1);
      check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rel_mem_hold", mem_data, 32'h11AD33AA);

      // Reset while a store waits
      xact(1'b0, 1'b1, 32'h20, 32'h11111111, 4'hF, d, e, lat);
      xact(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
      check("pre_rst_ld", d, 32'h11111111);
      is_memRead = 1'b0; is_memWrite = 1'b1; addr = 32'h20; wdata = 32'h22222222;
      byte_en = 4'hF; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("wait_mem_hold", mem_data, 32'h11111111);
      #1 rst_n = 1'b0;
      #1;
      check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("arst_mem_data", mem_data, 32'd0);
      check("arst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_rd = 0; exp_wr = 0; exp_err = 0;
      @(negedge clk);
      xact(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
      check("drop_st_ld", d, 32'h11111111);
      xact(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
      check("mem_kept_ld", d, 32'h11AD33AA);
      xact(1'b1, 1'b0, 32'h401, 32'h0, 4'h0, d, e, lat);

`ifdef DMEM_STATS_EN
      check("rd_count", 32'(rdc_a), 32'(exp_rd));
      check("wr_count", 32'(wrc_a), 32'(exp_wr));
      check("err_count", 32'(erc_a), 32'(exp_err));
`endif

      // Zero-latency instance
      sel = 1'b1;
      @(negedge clk);
      xact(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, d, e, lat);
      check("l0_st_lat", 32'(lat), 32'd1);
      check("l0_st_data", d, 32'd0);
      xact(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, d, e, lat);
      check("l0_ld_lat", 32'(lat), 32'd1);
      check("l0_ld_data", d, 32'hCAFEF00D);
      xact(1'b1, 1'b0, 32'h13, 32'h0, 4'h0, d, e, lat);
      check("l0_mis_err", 32'(e), 32'd1);

      is_memRead = 1'b1; is_memWrite = 1'b0; addr = 32'h40; req_valid = 1'b1; rsp_ready = 1'b1;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         if (req_valid && req_ready) acc++;
         if (i == 1) check("l0_burst_data", mem_data, 32'hCAFEF00D);
         @(negedge clk);
      end
      req_valid = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("l0_burst_accepts", 32'(acc), 32'd4);
`ifdef DMEM_STATS_EN
      check("l0_rd_count", 32'(rdc_b), 32'd5);
      check("l0_wr_count", 32'(wrc_b), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
